// File: rtl/multi_rate_counter.sv
// Rate-divided modulo-MODULUS up/down counter with selectable tick rate, pause,
// synchronous load and a registered wrap pulse.
module multi_rate_counter #(
  parameter int CLOCK_FREQUENCY = 500,
  parameter int COUNT_WIDTH     = 4,
  parameter int MODULUS         = 16,
  parameter int DIV_WIDTH       = $clog2(4*CLOCK_FREQUENCY)
) (
  input  logic                   ClockIn,
  input  logic                   Resetn,
  input  logic [1:0]             Speed,
  input  logic                   Dir,
  input  logic                   Pause,
  input  logic                   Load,
  input  logic [COUNT_WIDTH-1:0] LoadValue,
  output logic                   Tick,
  output logic [COUNT_WIDTH-1:0] CounterValue,
  output logic                   Wrap
);

  localparam logic [DIV_WIDTH-1:0]   RELOAD_X1  = '0;
  localparam logic [DIV_WIDTH-1:0]   RELOAD_CF  = DIV_WIDTH'(CLOCK_FREQUENCY - 1);
  localparam logic [DIV_WIDTH-1:0]   RELOAD_2CF = DIV_WIDTH'(2*CLOCK_FREQUENCY - 1);
  localparam logic [DIV_WIDTH-1:0]   RELOAD_4CF = DIV_WIDTH'(4*CLOCK_FREQUENCY - 1);
  localparam logic [DIV_WIDTH-1:0]   DIV_ZERO   = '0;
  localparam logic [DIV_WIDTH-1:0]   DIV_ONE    = DIV_WIDTH'(1);
  localparam logic [COUNT_WIDTH-1:0] CNT_ZERO   = '0;
  localparam logic [COUNT_WIDTH-1:0] CNT_ONE    = COUNT_WIDTH'(1);
  localparam logic [COUNT_WIDTH-1:0] CNT_MAX    = COUNT_WIDTH'(MODULUS - 1);
  // One extra bit so MODULUS == 2**COUNT_WIDTH is representable.
  localparam logic [COUNT_WIDTH:0]   MOD_EXT    = (COUNT_WIDTH+1)'(MODULUS);

  logic [DIV_WIDTH-1:0]   div_q, div_d;
  logic [1:0]             speed_q, speed_d;
  logic                   reload_pending_q, reload_pending_d;
  logic [COUNT_WIDTH-1:0] counter_q, counter_d;
  logic                   wrap_q, wrap_d;
  logic [DIV_WIDTH-1:0]   reload_val_s;
  logic                   rate_change_s;
  logic                   tick_s;
  logic [COUNT_WIDTH-1:0] load_clamped_s;

  // Divider reload value for the requested rate.
  always_comb begin
    reload_val_s = RELOAD_X1;
    case (Speed)
      2'b00:   reload_val_s = RELOAD_X1;
      2'b01:   reload_val_s = RELOAD_CF;
      2'b10:   reload_val_s = RELOAD_2CF;
      2'b11:   reload_val_s = RELOAD_4CF;
      default: reload_val_s = RELOAD_X1;
    endcase
  end

  assign rate_change_s = (Speed != speed_q);
  assign tick_s = (div_q == DIV_ZERO) & ~Pause & ~reload_pending_q & ~Load & ~rate_change_s;
  assign Tick   = tick_s;

  // Divider next state: any resync cause reloads without ticking.
  always_comb begin
    div_d            = div_q;
    speed_d          = Speed;
    reload_pending_d = 1'b0;
    if (reload_pending_q | Load | rate_change_s) begin
      div_d = reload_val_s;
    end else if (Pause) begin
      div_d = div_q;
    end else if (div_q == DIV_ZERO) begin
      div_d = reload_val_s;
    end else begin
      div_d = div_q - DIV_ONE;
    end
  end

  // Clamp out-of-range load data to the top of the count range.
  always_comb begin
    if ({1'b0, LoadValue} >= MOD_EXT) begin
      load_clamped_s = CNT_MAX;
    end else begin
      load_clamped_s = LoadValue;
    end
  end

  // Counter next state, load has priority over tick.
  always_comb begin
    counter_d = counter_q;
    wrap_d    = 1'b0;
    if (Load) begin
      counter_d = load_clamped_s;
    end else if (tick_s) begin
      if (Dir) begin
        if (counter_q == CNT_MAX) begin
          counter_d = CNT_ZERO;
          wrap_d    = 1'b1;
        end else begin
          counter_d = counter_q + CNT_ONE;
        end
      end else begin
        if (counter_q == CNT_ZERO) begin
          counter_d = CNT_MAX;
          wrap_d    = 1'b1;
        end else begin
          counter_d = counter_q - CNT_ONE;
        end
      end
    end else begin
      counter_d = counter_q;
    end
  end

  // State registers.
  always_ff @(posedge ClockIn or negedge Resetn) begin
    if (!Resetn) begin
      div_q            <= DIV_ZERO;
      speed_q          <= 2'b00;
      reload_pending_q <= 1'b1;
      counter_q        <= CNT_ZERO;
      wrap_q           <= 1'b0;
    end else begin
      div_q            <= div_d;
      speed_q          <= speed_d;
      reload_pending_q <= reload_pending_d;
      counter_q        <= counter_d;
      wrap_q           <= wrap_d;
    end
  end

  assign CounterValue = counter_q;
  assign Wrap         = wrap_q;

endmodule

// File: tb/tb_multi_rate_counter.sv
// Directed bench for multi_rate_counter: a modulo-10 and a modulo-16 instance share stimulus.
module tb_multi_rate_counter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] speed;
  logic       dir, pause, load;
  logic [3:0] load_value;
  logic       tick10, tick16, wrap10, wrap16;
  logic [3:0] cnt10, cnt16;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  multi_rate_counter #(.CLOCK_FREQUENCY(500), .COUNT_WIDTH(4), .MODULUS(10)) u_dut10 (
    .ClockIn(clk), .Resetn(rst_n), .Speed(speed), .Dir(dir), .Pause(pause), .Load(load),
    .LoadValue(load_value), .Tick(tick10), .CounterValue(cnt10), .Wrap(wrap10)
  );

  multi_rate_counter #(.CLOCK_FREQUENCY(500), .COUNT_WIDTH(4), .MODULUS(16)) u_dut16 (
    .ClockIn(clk), .Resetn(rst_n), .Speed(speed), .Dir(dir), .Pause(pause), .Load(load),
    .LoadValue(load_value), .Tick(tick16), .CounterValue(cnt16), .Wrap(wrap16)
  );

  typedef struct packed {
    logic [1:0] speed;
    logic       dir;
    logic       pause;
    logic       load;
    logic [3:0] lv;
    logic       tick;
    logic [3:0] c10;
    logic       w10;
    logic [3:0] c16;
    logic       w16;
  } vec_t;

  localparam int NVEC = 29;
  vec_t vecs [NVEC];

  function automatic vec_t mk(input logic dir_i, input logic pause_i, input logic load_i,
                              input logic [3:0] lv_i, input logic tick_i,
                              input logic [3:0] c10_i, input logic w10_i,
                              input logic [3:0] c16_i, input logic w16_i);
    vec_t v;
    v.speed = 2'b00;
    v.dir   = dir_i;
    v.pause = pause_i;
    v.load  = load_i;
    v.lv    = lv_i;
    v.tick  = tick_i;
    v.c10   = c10_i;
    v.w10   = w10_i;
    v.c16   = c16_i;
    v.w16   = w16_i;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic wait_tick(input int max_edges, output int n);
    n = 0;
    while (n <= max_edges) begin
      @(posedge clk);
      #1;
      n++;
      if (tick10 === 1'b1) break;
    end
  endtask

  int  n;
  logic bad;

  initial begin
    // Speed=00 stream: edge 1 reloads, edge k leaves count k-1.
    vecs[0] = mk(1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
    for (int k = 2; k <= 10; k++)
      vecs[k-1] = mk(1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 4'(k-1), 1'b0, 4'(k-1), 1'b0);
    vecs[10] = mk(1'b1, 1'b0, 1'b0, 4'd0,  1'b1, 4'd0, 1'b1, 4'd10, 1'b0);
    vecs[11] = mk(1'b1, 1'b0, 1'b0, 4'd0,  1'b1, 4'd1, 1'b0, 4'd11, 1'b0);
    vecs[12] = mk(1'b1, 1'b0, 1'b0, 4'd0,  1'b1, 4'd2, 1'b0, 4'd12, 1'b0);
    vecs[13] = mk(1'b1, 1'b0, 1'b0, 4'd0,  1'b1, 4'd3, 1'b0, 4'd13, 1'b0);
    vecs[14] = mk(1'b1, 1'b0, 1'b0, 4'd0,  1'b1, 4'd4, 1'b0, 4'd14, 1'b0);
    vecs[15] = mk(1'b1, 1'b0, 1'b0, 4'd0,  1'b1, 4'd5, 1'b0, 4'd15, 1'b0);
    vecs[16] = mk(1'b1, 1'b0, 1'b0, 4'd0,  1'b1, 4'd6, 1'b0, 4'd0,  1'b1);
    vecs[17] = mk(1'b1, 1'b0, 1'b0, 4'd0,  1'b1, 4'd7, 1'b0, 4'd1,  1'b0);
    vecs[18] = mk(1'b0, 1'b0, 1'b0, 4'd0,  1'b1, 4'd6, 1'b0, 4'd0,  1'b0);
    vecs[19] = mk(1'b0, 1'b0, 1'b0, 4'd0,  1'b1, 4'd5, 1'b0, 4'd15, 1'b1);
    vecs[20] = mk(1'b0, 1'b0, 1'b0, 4'd0,  1'b1, 4'd4, 1'b0, 4'd14, 1'b0);
    vecs[21] = mk(1'b0, 1'b0, 1'b1, 4'd12, 1'b0, 4'd9, 1'b0, 4'd12, 1'b0);
    vecs[22] = mk(1'b1, 1'b0, 1'b0, 4'd0,  1'b1, 4'd0, 1'b1, 4'd13, 1'b0);
    vecs[23] = mk(1'b1, 1'b0, 1'b1, 4'd15, 1'b0, 4'd9, 1'b0, 4'd15, 1'b0);
    vecs[24] = mk(1'b1, 1'b0, 1'b0, 4'd0,  1'b1, 4'd0, 1'b1, 4'd0,  1'b1);
    vecs[25] = mk(1'b1, 1'b1, 1'b0, 4'd0,  1'b0, 4'd0, 1'b0, 4'd0,  1'b0);
    vecs[26] = mk(1'b1, 1'b1, 1'b1, 4'd3,  1'b0, 4'd3, 1'b0, 4'd3,  1'b0);
    vecs[27] = mk(1'b0, 1'b0, 1'b0, 4'd0,  1'b1, 4'd2, 1'b0, 4'd2,  1'b0);
    vecs[28] = mk(1'b0, 1'b0, 1'b1, 4'd10, 1'b0, 4'd9, 1'b0, 4'd10, 1'b0);

    rst_n = 1'b0; speed = 2'b00; dir = 1'b1; pause = 1'b0; load = 1'b0; load_value = 4'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_cnt10", cnt10, 0);
    chk("reset_cnt16", cnt16, 0);
    chk("reset_wrap10", wrap10, 0);
    chk("reset_tick10", tick10, 0);
    rst_n = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      speed = vecs[i].speed; dir = vecs[i].dir; pause = vecs[i].pause;
      load = vecs[i].load;   load_value = vecs[i].lv;
      #1;
      chk($sformatf("vec%0d_tick10", i), tick10, vecs[i].tick);
      chk($sformatf("vec%0d_tick16", i), tick16, vecs[i].tick);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_cnt10", i),  cnt10,  vecs[i].c10);
      chk($sformatf("vec%0d_wrap10", i), wrap10, vecs[i].w10);
      chk($sformatf("vec%0d_cnt16", i),  cnt16,  vecs[i].c16);
      chk($sformatf("vec%0d_wrap16", i), wrap16, vecs[i].w16);
      @(negedge clk);
    end

    // Asynchronous reset between edges clears outputs immediately.
    load = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_cnt10", cnt10, 0);
    chk("async_rst_cnt16", cnt16, 0);
    chk("async_rst_wrap16", wrap16, 0);

    // Speed=01: first tick after edge 500, count steps at 501 and 1001.
    @(negedge clk);
    speed = 2'b01; dir = 1'b1; pause = 1'b0; load = 1'b0; rst_n = 1'b1;
    bad = 1'b0;
    for (int e = 1; e <= 499; e++) begin
      @(posedge clk); #1;
      if (tick10 !== 1'b0 || cnt10 !== 4'd0) bad = 1'b1;
    end
    chk("no_tick_before_500", bad, 0);
    @(posedge clk); #1;
    chk("tick_at_500", tick10, 1);
    chk("tick16_at_500", tick16, 1);
    chk("cnt_at_500", cnt10, 0);
    @(posedge clk); #1;
    chk("cnt10_at_501", cnt10, 1);
    chk("cnt16_at_501", cnt16, 1);
    chk("tick_after_501", tick10, 0);
    wait_tick(600, n);
    chk("second_tick_gap", n, 499);
    @(posedge clk); #1;
    chk("cnt_at_1001", cnt10, 2);

    // Pause 300 cycles with div at 400: nothing moves, then 400 edges to the tick.
    repeat (99) @(posedge clk);
    @(negedge clk);
    pause = 1'b1;
    bad = 1'b0;
    for (int e = 0; e < 300; e++) begin
      @(posedge clk); #1;
      if (tick10 !== 1'b0 || cnt10 !== 4'd2 || cnt16 !== 4'd2) bad = 1'b1;
    end
    chk("pause_frozen", bad, 0);
    @(negedge clk);
    pause = 1'b0;
    wait_tick(500, n);
    chk("tick_after_pause", n, 400);
    chk("cnt_after_pause", cnt10, 2);

    // Switch 01 -> 11 at div=100: resync, next tick 2000 edges later.
    @(posedge clk); #1;
    chk("cnt_step_3", cnt10, 3);
    repeat (399) @(posedge clk);
    @(negedge clk);
    speed = 2'b11;
    #1;
    chk("tick_on_speed_change", tick10, 0);
    wait_tick(2100, n);
    chk("tick_after_speed_change", n, 2000);
    chk("cnt_before_step_4", cnt16, 3);
    @(posedge clk); #1;
    chk("cnt_step_4", cnt16, 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
